// File: rtl/fpu_seq_pkg.sv
// Shared types, FP32 constants and classification helpers for the FP op sequencer.
package fpu_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } fpu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } seq_state_e;

   localparam logic [7:0]  EXP_ONES = 8'hFF;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF  = 32'h7F80_0000;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == EXP_ONES) && (x[22:0] != 23'd0);
   endfunction

   // Signalling NaN: NaN with the quiet bit (mantissa MSB) clear.
   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && !x[22];
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return x[30:0] == POS_INF[30:0];
   endfunction

   function automatic logic is_zero(input logic [31:0] x);
      return x[30:0] == 31'd0;
   endfunction

endpackage

// File: rtl/fpu_seq_classify.sv
// Combinational RISC-V fflags {NV,DZ,OF,UF,NX} from the operand bus and the selected unit result.
module fpu_seq_classify
   import fpu_seq_pkg::*;
(
   input  fpu_op_e     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] result,
   output logic [4:0]  flags
);

   logic nv;
   logic dz;
   logic of;
   logic uf;
   logic a_fin;
   logic b_fin;

   always_comb begin
      a_fin = !is_nan(a) && !is_inf(a);
      b_fin = !is_nan(b) && !is_inf(b);

      nv = is_snan(a) || is_snan(b);
      dz = 1'b0;
      case (op)
         OP_ADD: nv = nv || (is_inf(a) && is_inf(b) && (a[31] != b[31]));
         OP_SUB: nv = nv || (is_inf(a) && is_inf(b) && (a[31] == b[31]));
         OP_MUL: nv = nv || (is_zero(a) && is_inf(b)) || (is_inf(a) && is_zero(b));
         OP_DIV: begin
            nv = nv || (is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b));
            dz = a_fin && !is_zero(a) && is_zero(b);
         end
         default: nv = nv;
      endcase

      of = (result[30:23] == EXP_ONES) && a_fin && b_fin;
      uf = (result[30:23] == 8'd0) && (result[22:0] != 23'd0);

      flags = {nv, dz, of, uf, 1'b0};
   end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issue/collect sequencer for the combinational FP32 add/sub/mul/div units.
// Optional rsp_flags output is enabled with macro FPU_SEQ_FLAGS_EN.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | operands on the bus, counting down the unit settle time
// DONE  | result captured, waiting for the consumer handshake
module fpu_op_sequencer
   import fpu_seq_pkg::*;
#(
   parameter int ADD_LAT = 1,
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        unit_en,
   input  logic [31:0] add_o,
   input  logic [31:0] sub_ans,
   input  logic [31:0] mul_result,
   input  logic [31:0] div_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [1:0]  rsp_op,
`ifdef FPU_SEQ_FLAGS_EN
   output logic [4:0]  rsp_flags,
`endif
   output logic        busy
);

   localparam logic [3:0] ADD_CNT = 4'(ADD_LAT);
   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
   localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

   seq_state_e  state;
   seq_state_e  state_nxt;
   fpu_op_e     op_q;
   logic [3:0]  cnt;
   logic [3:0]  lat_sel;
   logic [31:0] mux_result;
   logic        accept;
   logic        last_cycle;

   assign req_ready  = (state == IDLE) && !reset;
   assign accept     = req_valid && req_ready;
   // <= 1 rather than == 1 so an out-of-range zero latency cannot stall in WAIT.
   assign last_cycle = (cnt <= 4'd1);

   always_comb begin
      lat_sel = ADD_CNT;
      case (req_op)
         2'b10:   lat_sel = MUL_CNT;
         2'b11:   lat_sel = DIV_CNT;
         default: lat_sel = ADD_CNT;
      endcase
   end

   always_comb begin
      mux_result = add_o;
      case (op_q)
         OP_SUB:  mux_result = sub_ans;
         OP_MUL:  mux_result = mul_result;
         OP_DIV:  mux_result = div_result;
         default: mux_result = add_o;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unit_en   = 1'b0;
      rsp_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: if (accept) state_nxt = WAIT;
         WAIT: begin
            unit_en = 1'b1;
            if (last_cycle) state_nxt = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FPU_SEQ_FLAGS_EN
   logic [4:0] flags_nxt;

   fpu_seq_classify u_classify (
      .op     (op_q),
      .a      (unit_a),
      .b      (unit_b),
      .result (mux_result),
      .flags  (flags_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 rsp_flags <= 5'd0;
      else if ((state == WAIT) && last_cycle)    rsp_flags <= flags_nxt;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         unit_a     <= 32'd0;
         unit_b     <= 32'd0;
         op_q       <= OP_ADD;
         cnt        <= 4'd0;
         rsp_result <= 32'd0;
         rsp_op     <= 2'd0;
      end else if (accept) begin
         unit_a <= req_a;
         unit_b <= req_b;
         op_q   <= fpu_op_e'(req_op);
         cnt    <= lat_sel;
      end else if (state == WAIT) begin
         cnt <= cnt - 4'd1;
         if (last_cycle) begin
            rsp_result <= mux_result;
            rsp_op     <= op_q;
         end
      end
   end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer (default latencies 1/2/4).
module tb_fpu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic        unit_en;
   logic [31:0] add_o;
   logic [31:0] sub_ans;
   logic [31:0] mul_result;
   logic [31:0] div_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_op;
   logic        busy;
`ifdef FPU_SEQ_FLAGS_EN
   logic [4:0]  rsp_flags;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fpu_op_sequencer #(.ADD_LAT(1), .MUL_LAT(2), .DIV_LAT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .unit_a     (unit_a),
      .unit_b     (unit_b),
      .unit_en    (unit_en),
      .add_o      (add_o),
      .sub_ans    (sub_ans),
      .mul_result (mul_result),
      .div_result (div_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_op     (rsp_op),
`ifdef FPU_SEQ_FLAGS_EN
      .rsp_flags  (rsp_flags),
`endif
      .busy       (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and step through its accept edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int edges);
      edges = 0;
      while (!rsp_valid && edges < 30) begin
         tick();
         edges++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || unit_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: ready=%b busy=%b valid=%b en=%b required all 0",
                  req_ready, busy, rsp_valid, unit_en);
      end
      checks++;
      if (unit_a !== 32'd0 || unit_b !== 32'd0 || rsp_result !== 32'd0 || rsp_op !== 2'd0) begin
         failures++;
         $display("FAIL reset_data: a=%h b=%h res=%h op=%0d required 0", unit_a, unit_b, rsp_result, rsp_op);
      end
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b required 1", req_ready);
      end
   endtask

   task automatic test_add();
      int edges;
      int en_cycles;
      add_o     = 32'h4070_0000;
      rsp_ready = 1'b0;
      issue(2'b00, 32'h3FC0_0000, 32'h4010_0000);
      edges = 1;
      en_cycles = 0;
      while (!rsp_valid && edges < 20) begin
         if (unit_en) en_cycles++;
         tick();
         edges++;
      end
      checks++;
      if (edges !== 2) begin
         failures++;
         $display("FAIL add_latency: edges=%0d required 2", edges);
      end
      checks++;
      if (en_cycles !== 1) begin
         failures++;
         $display("FAIL add_unit_en_cycles: got %0d required 1", en_cycles);
      end
      checks++;
      if (rsp_result !== 32'h4070_0000 || rsp_op !== 2'b00) begin
         failures++;
         $display("FAIL add_result: res=%h op=%0d required 40700000 op 0", rsp_result, rsp_op);
      end
      checks++;
      if (unit_a !== 32'h3FC0_0000 || unit_b !== 32'h4010_0000 || unit_en !== 1'b0) begin
         failures++;
         $display("FAIL add_bus: a=%h b=%h en=%b required 3fc00000 40100000 0", unit_a, unit_b, unit_en);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || unit_a !== 32'h3FC0_0000) begin
         failures++;
         $display("FAIL add_handshake: valid=%b ready=%b a=%h required 0 1 3fc00000",
                  rsp_valid, req_ready, unit_a);
      end
   endtask

   task automatic test_div();
      int edges;
      int bad;
      div_result = 32'h4040_0000;
      issue(2'b11, 32'h40C0_0000, 32'h4000_0000);
      edges = 1;
      bad = 0;
      while (!rsp_valid && edges < 20) begin
         if (req_ready !== 1'b0 || busy !== 1'b1) bad++;
         tick();
         edges++;
      end
      checks++;
      if (edges !== 5) begin
         failures++;
         $display("FAIL div_latency: edges=%0d required 5", edges);
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL div_ready_busy: %0d bad cycles required 0", bad);
      end
      checks++;
      if (rsp_result !== 32'h4040_0000 || rsp_op !== 2'b11 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL div_result: res=%h op=%0d ready=%b required 40400000 3 0",
                  rsp_result, rsp_op, req_ready);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int edges;
      int bad;
      mul_result = 32'hC090_0000;
      add_o      = 32'h1234_5678;
      issue(2'b10, 32'hBFC0_0000, 32'h4040_0000);
      wait_rsp(edges);
      checks++;
      if (rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_timeout: rsp_valid=%b required 1", rsp_valid);
      end
      req_op    = 2'b00;
      req_a     = 32'h3F80_0000;
      req_b     = 32'h3F80_0000;
      req_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_result !== 32'hC090_0000 || rsp_op !== 2'b10 ||
             req_ready !== 1'b0 || unit_a !== 32'hBFC0_0000) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL bp_hold: %0d unstable cycles required 0 (res=%h op=%0d a=%h)",
                  bad, rsp_result, rsp_op, unit_a);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: valid=%b busy=%b ready=%b required 0 0 1", rsp_valid, busy, req_ready);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || unit_a !== 32'h3F80_0000 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_pending_accept: busy=%b a=%h ready=%b required 1 3f800000 0",
                  busy, unit_a, req_ready);
      end
      wait_rsp(edges);
      checks++;
      if (rsp_result !== 32'h1234_5678 || rsp_op !== 2'b00) begin
         failures++;
         $display("FAIL bp_second_result: res=%h op=%0d required 12345678 0", rsp_result, rsp_op);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      int bad;
      mul_result = 32'hC090_0000;
      issue(2'b10, 32'hBFC0_0000, 32'h4040_0000);
      checks++;
      if (unit_en !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_in_wait: unit_en=%b required 1", unit_en);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (unit_a !== 32'd0 || unit_b !== 32'd0 || rsp_result !== 32'd0 || rsp_op !== 2'd0 ||
          unit_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_clear: a=%h b=%h res=%h op=%0d en=%b busy=%b valid=%b ready=%b required all 0",
                  unit_a, unit_b, rsp_result, rsp_op, unit_en, busy, rsp_valid, req_ready);
      end
      tick();
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL rst_mid_no_rsp: %0d cycles with valid/busy required 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res [2];
      logic [1:0]  ops [2];
      int got;
      int cyc;
      logic gap_low;
      logic mul_issued;
      sub_ans    = 32'h3F80_0000;
      mul_result = 32'hC090_0000;
      rsp_ready  = 1'b1;
      got = 0;
      gap_low = 1'b0;
      mul_issued = 1'b0;
      res[0] = '0; res[1] = '0; ops[0] = '0; ops[1] = '0;
      req_op    = 2'b01;
      req_a     = 32'h4000_0000;
      req_b     = 32'h3F80_0000;
      req_valid = 1'b1;
      tick();
      req_op = 2'b10;
      req_a  = 32'hBFC0_0000;
      req_b  = 32'h4040_0000;
      cyc = 0;
      while (got < 2 && cyc < 40) begin
         if (rsp_valid) begin
            res[got] = rsp_result;
            ops[got] = rsp_op;
            got++;
         end else if (got == 1 && !unit_en) begin
            gap_low = 1'b1;
         end
         if (req_ready && req_valid) mul_issued = 1'b1;
         tick();
         if (mul_issued) req_valid = 1'b0;
         cyc++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      checks++;
      if (got !== 2) begin
         failures++;
         $display("FAIL b2b_count: responses=%0d required 2", got);
      end
      checks++;
      if (res[0] !== 32'h3F80_0000 || ops[0] !== 2'b01) begin
         failures++;
         $display("FAIL b2b_first: res=%h op=%0d required 3f800000 1", res[0], ops[0]);
      end
      checks++;
      if (res[1] !== 32'hC090_0000 || ops[1] !== 2'b10) begin
         failures++;
         $display("FAIL b2b_second: res=%h op=%0d required c0900000 2", res[1], ops[1]);
      end
      checks++;
      if (gap_low !== 1'b1) begin
         failures++;
         $display("FAIL b2b_en_gap: unit_en low between ops=%b required 1", gap_low);
      end
      tick();
   endtask

`ifdef FPU_SEQ_FLAGS_EN
   task automatic test_flags();
      int edges;
      div_result = 32'h0000_0000;
      issue(2'b11, 32'h40A0_0000, 32'h0000_0000);
      wait_rsp(edges);
      checks++;
      if (rsp_flags !== 5'b01000) begin
         failures++;
         $display("FAIL flags_div_zero: got %b required 01000", rsp_flags);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      mul_result = 32'h7FC0_0000;
      issue(2'b10, 32'h0000_0000, 32'h7F80_0000);
      wait_rsp(edges);
      checks++;
      if (rsp_flags !== 5'b10000 || rsp_result !== 32'h7FC0_0000) begin
         failures++;
         $display("FAIL flags_mul_zero_inf: flags=%b res=%h required 10000 7fc00000", rsp_flags, rsp_result);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_a      = 32'd0;
      req_b      = 32'd0;
      rsp_ready  = 1'b0;
      add_o      = 32'd0;
      sub_ans    = 32'd0;
      mul_result = 32'd0;
      div_result = 32'd0;
      test_reset();
      test_add();
      test_div();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
`ifdef FPU_SEQ_FLAGS_EN
      test_flags();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
